// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the PPC->Simulink register bank.
// Big-endian OPB bit order: bit 0 is the MSB of every vector.
interface opb_register_bank_ppc2simulink_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [0:AW-1]   OPB_ABus;
  logic [0:DW/8-1] OPB_BE;
  logic [0:DW-1]   OPB_DBus;
  logic            OPB_RNW;
  logic            OPB_select;
  logic            OPB_seqAddr;
  logic [0:DW-1]   Sl_DBus;
  logic            Sl_errAck;
  logic            Sl_retry;
  logic            Sl_toutSup;
  logic            Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus,
    output OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry,
    input  Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus,
    input  OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry,
    output Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// C_NUM_REGS x 32-bit PPC->fabric control registers behind one OPB window.
// Define SHADOW_COMMIT_EN for shadowed writes committed via slot C_NUM_REGS.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01116000,
  parameter logic [31:0] C_HIGHADDR   = 32'h011160FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [32*C_NUM_REGS-1:0]    user_data_out,
  output logic [C_NUM_REGS-1:0]       user_load
);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_e;

  localparam int AW = C_OPB_AWIDTH;
  localparam int DW = C_OPB_DWIDTH;
  localparam int BW = DW / 8;
  localparam int IW = AW - 2;
  localparam logic [IW-1:0] NREG = IW'(C_NUM_REGS);
  localparam logic [AW-1:0] BASE = C_BASEADDR[AW-1:0];
  localparam logic [AW-1:0] HIGH = C_HIGHADDR[AW-1:0];
  localparam logic [DW-1:0] RVAL = C_RESET_VAL[DW-1:0];

  state_e state_q, state_d;

  logic [IW-1:0] idx_q, idx_d;
  logic          rnw_q, rnw_d;
  logic [BW-1:0] be_q, be_d;
  logic [DW-1:0] wdat_q, wdat_d;

  logic [DW-1:0] out_q [C_NUM_REGS];
  logic [DW-1:0] out_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] load_q, load_d;

`ifdef SHADOW_COMMIT_EN
  logic [DW-1:0] shd_q [C_NUM_REGS];
  logic [DW-1:0] shd_d [C_NUM_REGS];
  logic cmt_sel;
  logic wr_cmt;
`endif

  logic [AW-1:0] off;
  logic          hit;
  logic          in_ack;
  logic          reg_sel;
  logic          ok;
  logic          wr_reg;
  logic [DW-1:0] rdata;
  logic          unused_ok;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [BW-1:0] be
  );
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign off = opb.OPB_ABus - BASE;
  assign hit = opb.OPB_select
             && (opb.OPB_ABus >= BASE)
             && (opb.OPB_ABus <= HIGH);

  assign in_ack  = (state_q == S_ACK);
  assign reg_sel = (idx_q < NREG);
  assign wr_reg  = !rnw_q && reg_sel && (|be_q);

`ifdef SHADOW_COMMIT_EN
  assign cmt_sel = (idx_q == NREG);
  assign ok      = reg_sel || cmt_sel;
  // Commit bit is DBus[31], the LSB of the bottom byte lane.
  assign wr_cmt  = !rnw_q && cmt_sel && be_q[0] && wdat_q[0];
`else
  assign ok      = reg_sel;
`endif

  always_comb begin
    rdata = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (idx_q == IW'(k)) begin
`ifdef SHADOW_COMMIT_EN
        rdata = shd_q[k];
`else
        rdata = out_q[k];
`endif
      end
    end
  end

  assign opb.Sl_xferAck = in_ack && ok;
  assign opb.Sl_errAck  = in_ack && !ok;
  assign opb.Sl_DBus    = (in_ack && rnw_q && reg_sel) ? rdata : '0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign unused_ok = ^{off[1:0], opb.OPB_seqAddr};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rnw_d   = rnw_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    out_d   = out_q;
    load_d  = '0;
`ifdef SHADOW_COMMIT_EN
    shd_d   = shd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          idx_d   = off[AW-1:2];
          rnw_d   = opb.OPB_RNW;
          be_d    = opb.OPB_BE;
          wdat_d  = opb.OPB_DBus;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        unique case (1'b1)
          wr_reg: begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
              if (idx_q == IW'(k)) begin
`ifdef SHADOW_COMMIT_EN
                shd_d[k] = merge(shd_q[k], wdat_q, be_q);
`else
                out_d[k]  = merge(out_q[k], wdat_q, be_q);
                load_d[k] = 1'b1;
`endif
              end
            end
          end
`ifdef SHADOW_COMMIT_EN
          wr_cmt: begin
            out_d  = shd_q;
            load_d = '1;
          end
`endif
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rnw_q   <= 1'b1;
      be_q    <= '0;
      wdat_q  <= '0;
      load_q  <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        out_q[k] <= RVAL;
`ifdef SHADOW_COMMIT_EN
        shd_q[k] <= RVAL;
`endif
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rnw_q   <= rnw_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      load_q  <= load_d;
      out_q   <= out_d;
`ifdef SHADOW_COMMIT_EN
      shd_q   <= shd_d;
`endif
    end
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign user_data_out[32*k +: 32] = out_q[k];
  end

  assign user_load = load_q;

endmodule
